// File: rtl/display_pkg.sv
// Shared types and defaults for the seven-segment display scanner.
// Holds digit count, select width, FSM state enum and default timing.
package display_pkg;

    localparam int NUM_DIGITS       = 8;
    localparam int SEL_W            = 3;

    localparam int DEF_DIV          = 100000;
    localparam int DEF_BLANK        = 5000;
    localparam int DEF_BLINK_FRAMES = 50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        SHOW = 2'd2
    } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Control/status bundle between the scanner and its user.
// enable, blink_mask in; select, blank, frame_done, blink_phase out.
interface display_scan_ctrl_if;
    import display_pkg::*;

    logic                  enable;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [SEL_W-1:0]      select;
    logic                  blank;
    logic                  frame_done;
    logic                  blink_phase;

    modport master (
        output enable, blink_mask,
        input  select, blank, frame_done, blink_phase
    );

    modport slave (
        input  enable, blink_mask,
        output select, blank, frame_done, blink_phase
    );

endinterface

// File: rtl/blink_timer.sv
// Counts completed scan frames and toggles the blink phase.
// Ports: clk, rst, i_clr (clear count), i_tick (frame event), o_phase, o_phase_next.
module blink_timer
    import display_pkg::*;
#(
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_phase,
    output logic o_phase_next
);

    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_next;
    logic              r_phase;
    logic              w_wrap;

    assign w_wrap = i_tick && (r_fcnt == FCNT_LAST);

    always_comb begin
        w_fcnt_next = r_fcnt;
        if (i_clr) begin
            w_fcnt_next = '0;
        end else if (i_tick) begin
            w_fcnt_next = w_wrap ? '0 : r_fcnt + 1'b1;
        end
    end

    // Exposed so the parent can fold the new phase into blank on the same edge
    assign o_phase_next = r_phase ^ w_wrap;
    assign o_phase      = r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_fcnt  <= w_fcnt_next;
            r_phase <= o_phase_next;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 8-digit multiplexed display scanner: digit index, dead-time blanking, blink, frame pulse.
// Ports: clk, rst, bus (slave: enable, blink_mask -> select, blank, frame_done, blink_phase).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIV          = DEF_DIV,
    parameter int BLANK        = DEF_BLANK,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                clk,
    input  logic                rst,
    display_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_next;
    logic             r_blank;
    logic             w_blank_next;
    logic             r_frame;
    logic             w_frame_next;
    logic             w_slot_end;
    logic             w_in_dead;
    logic             w_phase;
    logic             w_phase_next;

    assign w_slot_end = (r_cnt == CNT_LAST);

    // Counters: cleared while disabled and on the IDLE->slot 0 start
    always_comb begin
        w_cnt_next   = '0;
        w_sel_next   = '0;
        w_frame_next = 1'b0;
        if (bus.enable && (r_state != IDLE)) begin
            w_cnt_next   = w_slot_end ? '0 : r_cnt + 1'b1;
            w_sel_next   = w_slot_end ? r_sel + 1'b1 : r_sel;
            w_frame_next = w_slot_end && (r_sel == SEL_LAST);
        end
    end

    // Zero dead time never enters DEAD; avoid a constant compare against 0
    generate
        if (BLANK > 0) begin : g_dead
            assign w_in_dead = (w_cnt_next < CNT_W'(BLANK));
        end else begin : g_no_dead
            assign w_in_dead = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_next = IDLE;
        if (bus.enable) begin
            w_state_next = w_in_dead ? DEAD : SHOW;
        end
        w_blank_next = (w_state_next != SHOW)
                     || (w_phase_next && bus.blink_mask[w_sel_next]);
    end

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (!bus.enable),
        .i_tick       (w_frame_next),
        .o_phase      (w_phase),
        .o_phase_next (w_phase_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_blank <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sel   <= w_sel_next;
            r_blank <= w_blank_next;
            r_frame <= w_frame_next;
        end
    end

    assign bus.select      = r_sel;
    assign bus.blank       = r_blank;
    assign bus.frame_done  = r_frame;
    assign bus.blink_phase = w_phase;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: two instances with different timing.
// A: DIV=4 BLANK=1 BLINK_FRAMES=2; B: DIV=2 BLANK=0 BLINK_FRAMES=1.
module tb_display_scan_ctrl;
    import display_pkg::*;

    localparam int A_DIV = 4;
    localparam int A_BLANK = 1;
    localparam int A_BF = 2;
    localparam int B_DIV = 2;
    localparam int B_BLANK = 0;
    localparam int B_BF = 1;

    typedef struct packed {
        logic [2:0] sel;
        logic       blank;
        logic       frame;
        logic       phase;
    } obs_t;

    localparam obs_t RST_OBS = '{sel: 3'd0, blank: 1'b1, frame: 1'b0, phase: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    display_scan_ctrl_if ifa ();
    display_scan_ctrl_if ifb ();

    display_scan_ctrl #(
        .DIV (A_DIV), .BLANK (A_BLANK), .BLINK_FRAMES (A_BF)
    ) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );

    display_scan_ctrl #(
        .DIV (B_DIV), .BLANK (B_BLANK), .BLINK_FRAMES (B_BF)
    ) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    obs_t qa[$];
    obs_t qb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: position within the 8-digit frame, per instance
    bit   m_run[2];
    int   m_pos[2];
    int   m_fc[2];
    bit   m_phase[2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0;
            m_pos[k] = 0;
            m_fc[k] = 0;
            m_phase[k] = 1'b0;
        end
    endfunction

    function automatic obs_t model_step(int k, bit en, logic [7:0] mask);
        int div = (k == 0) ? A_DIV : B_DIV;
        int blk = (k == 0) ? A_BLANK : B_BLANK;
        int bf = (k == 0) ? A_BF : B_BF;
        obs_t o;
        int c;
        o.frame = 1'b0;
        if (!en) begin
            m_run[k] = 1'b0;
            m_pos[k] = 0;
            m_fc[k] = 0;
        end else if (!m_run[k]) begin
            m_run[k] = 1'b1;
            m_pos[k] = 0;
        end else begin
            m_pos[k]++;
            if (m_pos[k] == 8 * div) begin
                m_pos[k] = 0;
                o.frame = 1'b1;
                m_fc[k]++;
                if (m_fc[k] == bf) begin
                    m_fc[k] = 0;
                    m_phase[k] = !m_phase[k];
                end
            end
        end
        o.sel = 3'(m_pos[k] / div);
        c = m_pos[k] % div;
        o.blank = !m_run[k] || (c < blk) || (m_phase[k] && mask[o.sel]);
        o.phase = m_phase[k];
        return o;
    endfunction

    function automatic obs_t obs_a();
        return {ifa.select, ifa.blank, ifa.frame_done, ifa.blink_phase};
    endfunction

    function automatic obs_t obs_b();
        return {ifb.select, ifb.blank, ifb.frame_done, ifb.blink_phase};
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("sel=%0d blank=%b frame=%b phase=%b",
                         o.sel, o.blank, o.frame, o.phase);
    endfunction

    task automatic tick_a(bit en, logic [7:0] mask);
        ifa.enable = en;
        ifa.blink_mask = mask;
        qa.push_back(model_step(0, en, mask));
        @(posedge clk);
        #1;
    endtask

    task automatic tick_b(bit en, logic [7:0] mask);
        ifb.enable = en;
        ifb.blink_mask = mask;
        qb.push_back(model_step(1, en, mask));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        ifa.enable = 1'b0;
        ifa.blink_mask = '0;
        ifb.enable = 1'b0;
        ifb.blink_mask = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        got = obs_a();
        n_checks++;
        if (got !== RST_OBS) begin
            n_errors++;
            $display("FAIL reset_a: got %s expected %s", fmt(got), fmt(RST_OBS));
        end
        got = obs_b();
        n_checks++;
        if (got !== RST_OBS) begin
            n_errors++;
            $display("FAIL reset_b: got %s expected %s", fmt(got), fmt(RST_OBS));
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        qa.delete();
        qb.delete();
    endtask

    task automatic test_normal_scan();
        obs_t exp;
        obs_t got;
        int pulses = 0;
        for (int i = 0; i < 68; i++) begin
            tick_a(1'b1, 8'h00);
            exp = qa.pop_front();
            got = obs_a();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL scan[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
            if (got.frame === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 2) begin
            n_errors++;
            $display("FAIL scan_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_blink();
        obs_t exp;
        obs_t got;
        for (int i = 0; i < 64; i++) begin
            tick_a(1'b1, 8'h04);
            exp = qa.pop_front();
            got = obs_a();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL blink[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_enable_drop();
        obs_t exp;
        obs_t got;
        bit found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick_a(1'b1, 8'h00);
            exp = qa.pop_front();
            got = obs_a();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL drop_pre[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
            if (m_pos[0] == 5 * A_DIV + 2) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL drop_reach: got no slot5/cnt2 expected it within 64 cycles");
        end
        for (int i = 0; i < 12; i++) begin
            tick_a(i >= 4, 8'h00);
            exp = qa.pop_front();
            got = obs_a();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL drop[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_wrap_corner();
        obs_t exp;
        obs_t got;
        bit found = 1'b0;
        bit ph;
        for (int i = 0; i < 200; i++) begin
            tick_a(1'b1, 8'h00);
            exp = qa.pop_front();
            got = obs_a();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL corner_pre[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
            if (m_fc[0] == A_BF - 1 && m_pos[0] == 8 * A_DIV - 1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL corner_reach: got no blink boundary expected one within 200 cycles");
        end
        ph = m_phase[0];
        for (int i = 0; i < 3; i++) begin
            tick_a(1'b0, 8'h00);
            exp = qa.pop_front();
            got = obs_a();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL corner[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
        n_checks++;
        if (ifa.blink_phase !== ph || ifa.frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL corner_hold: got phase=%b frame=%b expected phase=%b frame=0",
                     ifa.blink_phase, ifa.frame_done, ph);
        end
    endtask

    task automatic test_reset_mid();
        obs_t exp;
        obs_t got;
        for (int i = 0; i < 10; i++) begin
            tick_a(1'b1, 8'hFF);
            void'(qa.pop_front());
        end
        #2;
        rst = 1'b1;
        #1;
        got = obs_a();
        n_checks++;
        if (got !== RST_OBS) begin
            n_errors++;
            $display("FAIL reset_mid: got %s expected %s", fmt(got), fmt(RST_OBS));
        end
        #2;
        rst = 1'b0;
        model_reset();
        qa.delete();
        for (int i = 0; i < 8; i++) begin
            tick_a(1'b1, 8'h00);
            exp = qa.pop_front();
            got = obs_a();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL restart[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
        end
        tick_a(1'b0, 8'h00);
        void'(qa.pop_front());
    endtask

    task automatic test_blank0();
        obs_t exp;
        obs_t got;
        int pulses = 0;
        for (int i = 0; i < 80; i++) begin
            tick_b(1'b1, (i < 40) ? 8'h00 : 8'h80);
            exp = qb.pop_front();
            got = obs_b();
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL blank0[%0d]: got %s expected %s", i, fmt(got), fmt(exp));
            end
            if (i < 40 && got.frame === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 2) begin
            n_errors++;
            $display("FAIL blank0_pulses: got %0d expected 2", pulses);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_normal_scan();
        test_blink();
        test_enable_drop();
        test_wrap_corner();
        test_reset_mid();
        test_blank0();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
